// File: rtl/washer_ctrl.sv
// washer_ctrl: washing-machine program sequencer covering wash (xi), rinse (piao) and spin (tuo).
// Define PAUSE_EN to let start_btn pause and resume a running program.
module washer_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       power_btn,
  input  logic       start_btn,
  input  logic       mode_btn,
  input  logic       weight_btn,
  output logic [3:0] state,
  output logic [2:0] status_mode,
  output logic [1:0] status_weight,
  output logic [3:0] timer_set,
  output logic [7:0] water_line,
  output logic       done
);

`ifdef PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StStart    = 4'd0,
    StXi1      = 4'd1,
    StXi2      = 4'd2,
    StPiao1    = 4'd3,
    StPiao2    = 4'd4,
    StPiao3    = 4'd5,
    StPiao4    = 4'd6,
    StTuo1     = 4'd7,
    StTuo2     = 4'd8,
    StFinish   = 4'd9,
    StShutDown = 4'd10,
    StPause    = 4'd11
  } state_e;

  state_e     state_q, state_d, saved_q, saved_d, nxt;
  logic [2:0] mode_q, mode_d;
  logic [1:0] weight_q, weight_d;
  logic [3:0] timer_q, timer_d;
  logic [7:0] water_q, water_d;

  function automatic state_e first_phase(input logic [2:0] mode);
    case (mode)
      3'd0, 3'd1, 3'd2: return StXi1;
      3'd3, 3'd4:       return StPiao1;
      default:          return StTuo1;
    endcase
  endfunction

  // Short programs leave the full sequence early, straight into finish.
  function automatic state_e next_phase(input state_e ph, input logic [2:0] mode);
    case (ph)
      StXi1:   return StXi2;
      StXi2:   return (mode == 3'd1) ? StFinish : StPiao1;
      StPiao1: return StPiao2;
      StPiao2: return StPiao3;
      StPiao3: return StPiao4;
      StPiao4: return (mode == 3'd2 || mode == 3'd3) ? StFinish : StTuo1;
      StTuo1:  return StTuo2;
      default: return StFinish;
    endcase
  endfunction

  function automatic logic [3:0] phase_len(input state_e ph, input logic [1:0] w);
    case (ph)
      StXi1, StPiao3:                   return 4'd2 + {2'b00, w};
      StXi2:                            return 4'd9;
      StPiao4:                          return 4'd6;
      StPiao1, StPiao2, StTuo1, StTuo2: return 4'd3;
      default:                          return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] water_step(input state_e ph, input logic [7:0] lvl);
    case (ph)
      StXi1, StPiao3:  return lvl + 8'd10;
      StPiao1, StTuo1: return (lvl >= 8'd10) ? lvl - 8'd10 : 8'd0;
      default:         return lvl;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    mode_d   = mode_q;
    weight_d = weight_q;
    timer_d  = timer_q;
    water_d  = water_q;
    nxt      = next_phase(state_q, mode_q);

    if (power_btn) begin
      if (state_q == StShutDown) begin
        state_d = StStart;
      end else begin
        state_d  = StShutDown;
        mode_d   = 3'd0;
        weight_d = 2'd0;
        timer_d  = 4'd0;
        water_d  = 8'd0;
      end
    end else begin
      case (state_q)
        StStart: begin
          if (mode_btn) mode_d = (mode_q == 3'd5) ? 3'd0 : mode_q + 3'd1;
          if (weight_btn) weight_d = weight_q + 2'd1;
          if (start_btn) begin
            state_d = first_phase(mode_d);
            timer_d = phase_len(state_d, weight_d);
          end
        end
        StXi1, StXi2, StPiao1, StPiao2, StPiao3, StPiao4, StTuo1, StTuo2: begin
          if (PauseEn && start_btn) begin
            saved_d = state_q;
            state_d = StPause;
          end else if (tick_1hz) begin
            water_d = water_step(state_q, water_q);
            if (timer_q <= 4'd1) begin
              state_d = nxt;
              timer_d = phase_len(nxt, weight_q);
              if (nxt inside {StPiao2, StTuo2, StFinish}) water_d = 8'd0;
            end else begin
              timer_d = timer_q - 4'd1;
            end
          end
        end
        StFinish: begin
          if (start_btn) state_d = StStart;
        end
        StShutDown: begin
          state_d = StShutDown;
        end
        StPause: begin
          // Timer and water stay frozen; only the phase is restored.
          if (!PauseEn) state_d = StStart;
          else if (start_btn) state_d = saved_q;
        end
        default: state_d = StStart;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StStart;
      saved_q  <= StStart;
      mode_q   <= 3'd0;
      weight_q <= 2'd0;
      timer_q  <= 4'd0;
      water_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      mode_q   <= mode_d;
      weight_q <= weight_d;
      timer_q  <= timer_d;
      water_q  <= water_d;
    end
  end

  assign state         = state_q;
  assign status_mode   = mode_q;
  assign status_weight = weight_q;
  assign timer_set     = timer_q;
  assign water_line    = water_q;
  assign done          = (state_q == StFinish);

endmodule

// File: tb/tb_washer_ctrl.sv
// tb_washer_ctrl: vector table, directed program runs and random stimulus against a
// program-range reference model of washer_ctrl.
module tb_washer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, power_btn = 1'b0, start_btn = 1'b0;
  logic       mode_btn = 1'b0, weight_btn = 1'b0;
  logic [3:0] state;
  logic [2:0] status_mode;
  logic [1:0] status_weight;
  logic [3:0] timer_set;
  logic [7:0] water_line;
  logic       done;

  always #5 clk = ~clk;

`ifdef PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  washer_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .power_btn    (power_btn),
    .start_btn    (start_btn),
    .mode_btn     (mode_btn),
    .weight_btn   (weight_btn),
    .state        (state),
    .status_mode  (status_mode),
    .status_weight(status_weight),
    .timer_set    (timer_set),
    .water_line   (water_line),
    .done         (done)
  );

  int nvec = 0;
  int nfail = 0;

  // Reference model: each program is a contiguous range of phase codes.
  int first_of [6] = '{1, 1, 1, 3, 3, 7};
  int last_of  [6] = '{8, 2, 6, 6, 8, 8};
  bit m_off, m_run, m_fin, m_pause;
  int m_cur, m_last, m_rem, m_water, m_mode, m_weight;

  function automatic int phase_secs(int ph, int w);
    case (ph)
      1, 5:    return 2 + w;
      2:       return 9;
      6:       return 6;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_off = 0; m_run = 0; m_fin = 0; m_pause = 0;
    m_cur = 0; m_last = 0; m_rem = 0; m_water = 0; m_mode = 0; m_weight = 0;
  endtask

  task automatic model_step(int pw, int st, int md, int wt, int tk);
    if (pw != 0) begin
      if (m_off) m_off = 0;
      else begin
        model_reset();
        m_off = 1;
      end
      return;
    end
    if (m_off) return;
    if (m_fin) begin
      if (st != 0) m_fin = 0;
      return;
    end
    if (m_pause) begin
      if (st != 0) m_pause = 0;
      return;
    end
    if (m_run) begin
      if (PauseEn && st != 0) begin
        m_pause = 1;
        return;
      end
      if (tk != 0) begin
        if (m_cur == 1 || m_cur == 5) m_water += 10;
        else if (m_cur == 3 || m_cur == 7) m_water = (m_water >= 10) ? m_water - 10 : 0;
        m_rem--;
        if (m_rem == 0) begin
          if (m_cur == m_last) begin
            m_run = 0; m_fin = 1; m_water = 0; m_rem = 0;
          end else begin
            m_cur++;
            m_rem = phase_secs(m_cur, m_weight);
            if (m_cur == 4 || m_cur == 8) m_water = 0;
          end
        end
      end
      return;
    end
    if (md != 0) m_mode = (m_mode + 1) % 6;
    if (wt != 0) m_weight = (m_weight + 1) % 4;
    if (st != 0) begin
      m_run  = 1;
      m_cur  = first_of[m_mode];
      m_last = last_of[m_mode];
      m_rem  = phase_secs(m_cur, m_weight);
    end
  endtask

  function automatic int m_state();
    if (m_off) return 10;
    if (m_pause) return 11;
    if (m_fin) return 9;
    if (m_run) return m_cur;
    return 0;
  endfunction

  task automatic check(string name, int es, int em, int ew, int et, int el, int ed);
    nvec++;
    if (int'(state) != es || int'(status_mode) != em || int'(status_weight) != ew ||
        int'(timer_set) != et || int'(water_line) != el || int'(done) != ed) begin
      nfail++;
      $display("FAIL %s: got state=%0d mode=%0d weight=%0d timer=%0d water=%0d done=%0d, want %0d %0d %0d %0d %0d %0d",
               name, state, status_mode, status_weight, timer_set, water_line, done,
               es, em, ew, et, el, ed);
    end
  endtask

  task automatic check_model(string name);
    check(name, m_state(), m_mode, m_weight, (m_run || m_pause) ? m_rem : 0, m_water,
          (m_state() == 9) ? 1 : 0);
  endtask

  task automatic expect_int(string name, int got, int want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic expect_str(string name, string got, string want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got '%s', want '%s'", name, got, want);
    end
  endtask

  task automatic cycle(int pw, int st, int md, int wt, int tk);
    power_btn  = (pw != 0);
    start_btn  = (st != 0);
    mode_btn   = (md != 0);
    weight_btn = (wt != 0);
    tick_1hz   = (tk != 0);
    model_step(pw, st, md, wt, tk);
    @(posedge clk);
    #1;
    power_btn = 1'b0; start_btn = 1'b0; mode_btn = 1'b0; weight_btn = 1'b0; tick_1hz = 1'b0;
  endtask

  // Tick until finish (bounded); records phase order and the level when leaving xi_1.
  task automatic run_program(output int ticks, output string seq, output int fill);
    logic [3:0] prev;
    ticks = 0;
    fill  = -1;
    prev  = state;
    seq   = $sformatf("%0d", state);
    for (int i = 0; i < 200 && state != 4'd9; i++) begin
      cycle(0, 0, 0, 0, 1);
      ticks++;
      check_model("run_step");
      if (state != prev) begin
        if (prev == 4'd1) fill = int'(water_line);
        seq  = {seq, $sformatf(" %0d", state)};
        prev = state;
      end
    end
  endtask

  typedef struct {
    int pw, st, md, wt, tk;
    int e_state, e_mode, e_weight, e_timer, e_water;
  } vec_t;

  vec_t tbl [13];
  int   ticks, fill;
  string seq;
  int   r_pw, r_st, r_md, r_wt, r_tk;

  initial begin
    tbl[0]  = '{0, 0, 1, 0, 0,  0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0,  0, 2, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0,  0, 2, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0,  1, 2, 1, 3, 0};
    tbl[4]  = '{0, 0, 0, 0, 1,  1, 2, 1, 2, 10};
    tbl[5]  = '{0, 0, 0, 0, 1,  1, 2, 1, 1, 20};
    tbl[6]  = '{0, 0, 0, 0, 1,  2, 2, 1, 9, 30};
    tbl[7]  = '{0, 0, 0, 0, 1,  2, 2, 1, 8, 30};
    tbl[8]  = '{1, 0, 0, 0, 0,  10, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1,  10, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0,  10, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 1, 0,  10, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].pw, tbl[i].st, tbl[i].md, tbl[i].wt, tbl[i].tk);
      check($sformatf("tbl%0d", i), tbl[i].e_state, tbl[i].e_mode, tbl[i].e_weight,
            tbl[i].e_timer, tbl[i].e_water, 0);
    end

    // Mode 0, weight 3: whole program.
    repeat (3) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 1);
    check("full_start", 1, 0, 3, 5, 0, 0);
    run_program(ticks, seq, fill);
    expect_int("full_ticks", ticks, 37);
    expect_str("full_seq", seq, "1 2 3 4 5 6 7 8 9");
    expect_int("full_fill", fill, 50);
    check("full_done", 9, 0, 3, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    check("finish_holds", 9, 0, 3, 0, 0, 1);

    // Back to start keeping settings, then mode 1 with weight wrapping 3 -> 0.
    cycle(0, 1, 0, 0, 0);
    check("fin_to_start", 0, 0, 3, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    check("weight_wrap", 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("m1_start", 1, 1, 0, 2, 0, 0);
    run_program(ticks, seq, fill);
    expect_int("m1_ticks", ticks, 11);
    expect_str("m1_seq", seq, "1 2 9");
    expect_int("m1_fill", fill, 20);

    // Power together with start in piao_2.
    cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("m3_start", 3, 3, 0, 3, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1);
    check("m3_piao2", 4, 3, 0, 3, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check("pwr_prio", 10, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("off_tick", 10, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("pwr_on", 0, 0, 0, 0, 0, 0);

    // Mode 3, weight 1: start_btn in piao_3 with two seconds left.
    repeat (3) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    check("p3_start", 3, 3, 1, 3, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 1);
    check("p3_enter", 5, 3, 1, 3, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("p3_t2", 5, 3, 1, 2, 10, 0);
`ifdef PAUSE_EN
    cycle(0, 1, 0, 0, 1);
    check("pause", 11, 3, 1, 2, 10, 0);
    repeat (5) cycle(0, 0, 0, 0, 1);
    check("pause_ticks", 11, 3, 1, 2, 10, 0);
    cycle(0, 0, 1, 1, 0);
    check("pause_btns", 11, 3, 1, 2, 10, 0);
    cycle(0, 1, 0, 0, 0);
    check("resume", 5, 3, 1, 2, 10, 0);
    cycle(0, 0, 0, 0, 1);
`else
    cycle(0, 1, 0, 0, 0);
    check("start_ignored", 5, 3, 1, 2, 10, 0);
    cycle(0, 1, 0, 0, 1);
`endif
    check("p3_t1", 5, 3, 1, 1, 20, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("p3_off_on", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in tuo_1 with mode 5, weight 2.
    repeat (5) cycle(0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    check("m5_start", 7, 5, 2, 3, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("m5_tick", 7, 5, 2, 2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 0, 0, 0, 1);
    check("no_resume", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      r_pw = ($urandom_range(199) == 0) ? 1 : 0;
      r_st = ($urandom_range(99) < 6) ? 1 : 0;
      r_md = ($urandom_range(99) < 10) ? 1 : 0;
      r_wt = ($urandom_range(99) < 10) ? 1 : 0;
      r_tk = ($urandom_range(99) < 35) ? 1 : 0;
      cycle(r_pw, r_st, r_md, r_wt, r_tk);
      check_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
